serial_frame_tx: RTL and testbench
==================================

# serial_frame_tx

Parallel-to-serial frame transmitter. Accepts a parallel word from an upstream register stage on a start request and shifts it out on a single line as a framed serial stream: start bit, data LSB-first, stop bit. Each bit is held for a programmable number of clocks. The block is the sending end of the parallel register path: it consumes a parallel word and drives a serial line for a downstream receiver.

## Interface
- WIDTH, 8: data bits per frame, ≥1.
- DIV, 4: clocks per serial bit, ≥1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- PI  input  WIDTH  parallel word, sampled only on frame accept.
- start  input  1  request to send PI; level-sampled each rising edge.
- SO  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-clock pulse when a frame completes.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - SO=1, busy=0.
  - start=1 at a rising edge accepts the frame: PI is latched into the shift register, the bit counter and divider are cleared, and the state moves to START.
- START: SO=0 for DIV clocks, then DATA.
- DATA:
  - SO = shift register bit 0.
  - Every DIV clocks the register shifts right by one and the bit index increments.
  - After WIDTH bits, the state moves to STOP.
- STOP: SO=1 for DIV clocks, then IDLE.
- done and IDLE: on the edge leaving STOP, done=1 for exactly one clock and busy drops to 0 on the same edge.
- Divider: counts 0..DIV-1. It wraps to 0 on the edge that advances the bit. Its width is max(1, clog2(DIV)).
- Bit index: counts 0..WIDTH-1. It has no wrap-around inside a frame.
- start while busy=1 is ignored. Nothing is queued, and the in-flight frame is unaffected.
- PI changes after accept do not affect the frame in progress.
- Reset:
  - Takes effect immediately, including mid-frame.
  - Outputs: SO=1, busy=0, done=0.
  - Internal: state IDLE, divider=0, bit index=0, shift register=0.
  - A frame cut off by reset is abandoned. done is not asserted for it.
- start held high continuously sends back-to-back frames, separated by one IDLE clock.

## Timing
- Let edge 0 be the accept edge.
- busy=1 and SO=0 from edge 0.
- Data bit k (k=0..WIDTH-1) drives SO from edge (1+k)·DIV to edge (2+k)·DIV.
- The stop bit drives SO from edge (WIDTH+1)·DIV to edge (WIDTH+2)·DIV.
- At edge (WIDTH+2)·DIV: busy=0, done=1, SO=1. done drops at the next edge.
- Frame length is (WIDTH+2)·DIV clocks.
- The earliest next accept is edge (WIDTH+2)·DIV+1. start sampled during the done cycle is accepted.
- DIV=1: one clock per bit, frame length WIDTH+2.
- All outputs are registered. There is no combinational path from start or PI to SO, busy or done.

## Test plan
- **Reset values:** hold rst=1 for 3 clocks with start=1 → SO=1, busy=0, done=0 throughout. After release with start=0, the outputs stay unchanged.
- **Single frame (WIDTH=8, DIV=4, PI=8'h94):**
  - Pulse start for 1 clock → SO sequence, each bit held 4 clocks: 0 | 0,0,1,0,1,0,0,1 | 1.
  - busy is high for 40 clocks, and done pulses exactly once at edge 40.
- **Ignored start and PI stability:**
  - During that frame, assert start at edge 10 and change PI to 8'hFF at edge 5.
  - Required: the serial stream is unchanged and no second frame follows.
- **Back-to-back frames:**
  - Hold start=1, PI=8'h01, DIV=1.
  - Required: frames of 10 clocks (0,1,0,0,0,0,0,0,0,1) separated by one SO=1 idle clock, with done pulsing every 11 clocks.
- **Reset mid-frame:**
  - Assert rst asynchronously between edges during data bit 3.
  - Required: SO=1 and busy=0 immediately, with no done.
  - Then accept a new frame with PI=8'h5A, which transmits correctly from its start bit.
- **Boundary data:** PI=8'h00 and PI=8'hFF with DIV=4 → SO is low for 36 clocks then high for 4, and low for 4 then high for 36, respectively.

Source files
------------

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial frame transmitter.
// Sends start bit (0), WIDTH data bits LSB-first, then stop bit (1).
// Each bit is held for DIV clocks. SO, busy and done are all registered.
module serial_frame_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PI,
    input  logic             start,
    output logic             SO,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             so_q, so_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;

    // Divider reaches its last count: the current bit period ends at this edge.
    assign tick = (div_q == DIV_LAST);

    // State, divider, bit index and shift register next-state logic.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_START;
                    sh_d    = PI;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    div_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    div_d = '0;
                    sh_d  = sh_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    div_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency relative to the state change.
    always_comb begin
        so_d   = 1'b1;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
        case (state_d)
            ST_START: so_d = 1'b0;
            ST_DATA:  so_d = sh_d[0];
            default:  so_d = 1'b1;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            so_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SO   = so_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Testbench for serial_frame_tx: two instances (DIV=4 and DIV=1), each
// checked every cycle against a frame-time model, plus literal checks.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] PI4 = 8'h00;
    logic [7:0] PI1 = 8'h00;
    logic       start4 = 1'b0;
    logic       start1 = 1'b0;
    logic       SO4, busy4, done4;
    logic       SO1, busy1, done1;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    serial_frame_tx #(.WIDTH(8), .DIV(4)) u_dut4 (
        .clk  (clk),
        .rst  (rst),
        .PI   (PI4),
        .start(start4),
        .SO   (SO4),
        .busy (busy4),
        .done (done4)
    );

    serial_frame_tx #(.WIDTH(8), .DIV(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .PI   (PI1),
        .start(start1),
        .SO   (SO1),
        .busy (busy1),
        .done (done1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: time t since the accept edge selects the frame bit t/div.
    function automatic logic m_so(input logic act, input int t, input logic [7:0] w, input int div);
        int idx;
        if (!act) return 1'b1;
        idx = t / div;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return w[idx-1];
        return 1'b1;
    endfunction

    logic       act4 = 1'b0, act1 = 1'b0;
    logic       dn4 = 1'b0, dn1 = 1'b0;
    int         t4 = 0, t1 = 0;
    logic [7:0] w4 = 8'h00, w1 = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            act4 = 1'b0; dn4 = 1'b0; t4 = 0;
            act1 = 1'b0; dn1 = 1'b0; t1 = 0;
        end else begin
            dn4 = 1'b0;
            if (act4) begin
                t4++;
                if (t4 == 10 * 4) begin act4 = 1'b0; dn4 = 1'b1; end
            end else if (start4) begin
                act4 = 1'b1; t4 = 0; w4 = PI4;
            end
            dn1 = 1'b0;
            if (act1) begin
                t1++;
                if (t1 == 10 * 1) begin act1 = 1'b0; dn1 = 1'b1; end
            end else if (start1) begin
                act1 = 1'b1; t1 = 0; w1 = PI1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("so4",   SO4,   m_so(act4, t4, w4, 4));
            check("busy4", busy4, act4);
            check("done4", done4, dn4);
            check("so1",   SO1,   m_so(act1, t1, w1, 1));
            check("busy1", busy1, act1);
            check("done1", done1, dn1);
        end
    end

    task automatic rst_outputs_check(input string tag);
        check({tag, "_so4"},   SO4,   1'b1);
        check({tag, "_busy4"}, busy4, 1'b0);
        check({tag, "_done4"}, done4, 1'b0);
        check({tag, "_so1"},   SO1,   1'b1);
        check({tag, "_busy1"}, busy1, 1'b0);
        check({tag, "_done1"}, done1, 1'b0);
    endtask

    // One DIV=4 frame; optionally disturb PI and start mid-frame.
    task automatic frame4(input logic [7:0] w, input logic meddle,
                          output logic [39:0] cap, output int busy_cnt, output int done_cnt);
        cap = '0;
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        PI4 = w;
        start4 = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k < 40) cap[k] = SO4;
            busy_cnt += int'(busy4);
            done_cnt += int'(done4);
            if (k == 40) begin
                check("frame_done_at_end", done4, 1'b1);
                check("frame_busy_at_end", busy4, 1'b0);
            end
            if (k == 0) start4 = 1'b0;
            if (meddle) begin
                if (k == 5)  PI4 = 8'hFF;
                if (k == 9)  start4 = 1'b1;
                if (k == 10) start4 = 1'b0;
            end
        end
    endtask

    logic [39:0] cap;
    logic [21:0] cap1;
    int          bc, dc;
    logic        hold4 = 1'b0, hold1 = 1'b0;

    initial begin
        #2 rst = 1'b1;
        chk_en = 1'b1;

        // Reset held with start asserted.
        start4 = 1'b1;
        start1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst_outputs_check("rst_hold");
        end
        start4 = 1'b0;
        start1 = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst_outputs_check("rst_release");
        end

        // Single frame with ignored start and PI change.
        frame4(8'h94, 1'b1, cap, bc, dc);
        check("frame94_so", cap, 40'hFF00F0F000);
        check("frame94_busy_cnt", bc, 40);
        check("frame94_done_cnt", dc, 1);

        // Back-to-back frames at DIV=1.
        @(negedge clk);
        PI1 = 8'h01;
        start1 = 1'b1;
        dc = 0;
        for (int k = 0; k < 33; k++) begin
            @(negedge clk);
            if (k < 22) cap1[k] = SO1;
            if (k == 10 || k == 21 || k == 32) check("b2b_done_pos", done1, 1'b1);
            dc += int'(done1);
        end
        start1 = 1'b0;
        check("b2b_period0", cap1[10:0], 11'h602);
        check("b2b_period1", cap1[21:11], 11'h602);
        check("b2b_done_cnt", dc, 3);
        repeat (15) @(negedge clk);

        // Reset during data bit 3, then a clean frame.
        @(negedge clk);
        PI4 = 8'hC3;
        start4 = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            if (k == 0) start4 = 1'b0;
        end
        #1 rst = 1'b1;
        #1 rst_outputs_check("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        dc = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            dc += int'(done4);
        end
        check("rst_mid_no_done", dc, 0);
        frame4(8'h5A, 1'b0, cap, bc, dc);
        check("frame5a_so", cap, 40'hF0F0FF0F00);
        check("frame5a_done_cnt", dc, 1);

        // Boundary data words.
        frame4(8'h00, 1'b0, cap, bc, dc);
        check("frame00_so", cap, 40'hF000000000);
        frame4(8'hFF, 1'b0, cap, bc, dc);
        check("frameFF_so", cap, 40'hFFFFFFFFF0);

        // Randomized traffic with occasional asynchronous reset.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            PI4 = 8'($urandom);
            PI1 = 8'($urandom);
            if ($urandom_range(0, 15) == 0) hold4 = ~hold4;
            if ($urandom_range(0, 15) == 0) hold1 = ~hold1;
            start4 = hold4 | ($urandom_range(0, 9) == 0);
            start1 = hold1 | ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #1 rst = 1'b1;
                #1 rst_outputs_check("rst_rand");
                #1 rst = 1'b0;
            end
        end
        start4 = 1'b0;
        start1 = 1'b0;
        repeat (50) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
